// File: rtl/q3_arb_pkg.sv
// q3_arb_pkg
//   Shared definitions for the q3 serial arbiter:
//     - state_t      : frame controller states (idle, shifting, inter-frame gap)
//     - Q3_*_DEFAULT : default frame width and gap length
//     - cnt_width()  : width of the shared bit/gap counter, $clog2(max(W,GAP)+1)
package q3_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int Q3_W_DEFAULT   = 8;
    localparam int Q3_GAP_DEFAULT = 1;

    // One counter serves both the SHIFT and GAP phases, so it must be wide
    // enough for whichever phase is longer.
    function automatic int cnt_width(input int w, input int gap);
        int m;
        m = (w > gap) ? w : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/q3_serial_arb_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter.
//   Ports:
//     c    in   clock
//     rst  in   asynchronous active-high reset (ptr -> 0)
//     req  in   [1:0] request vector
//     en   in   arbitration enable; no grant is produced while low
//     gnt  out  [1:0] one-hot (or zero) grant, combinational
//   ptr names the preferred requester. A lone requester always wins; with
//   both requesting, ptr decides. ptr moves to the other index after a grant.
module rr_arb2 (
    input  logic       c,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req[0] && req[1]) begin
                gnt = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
        // After granting k the other requester becomes preferred.
        if (en && (gnt != 2'b00)) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/q3_serial_arb.sv
// q3_serial_arb
//   Shares one bit-serial line (the q3 detector's input) between two word
//   producers. A granted W-bit word is shifted out LSB-first, followed by
//   GAP idle cycles. Detector pulses returned on det (one cycle latency)
//   are counted over the matching window and reported in hits with a
//   one-cycle done pulse.
//   Ports:
//     c              in   clock
//     rst            in   asynchronous active-high reset
//     req0/req1      in   word requests, held until granted
//     data0/data1    in   [W-1:0] words, sampled in the grant cycle
//     gnt0/gnt1      out  one-cycle grant pulses (combinational in IDLE)
//     so / sv        out  serial bit / serial valid
//     det            in   detector output
//     hits           out  [HW-1:0] detector hits over the last frame window
//     done           out  one-cycle pulse, hits is final
//     owner          out  requester index of the last/current frame
module q3_serial_arb
    import q3_arb_pkg::*;
#(
    parameter int W   = Q3_W_DEFAULT,
    parameter int GAP = Q3_GAP_DEFAULT,
    parameter int HW  = $clog2(W + 1)
) (
    input  logic          c,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [W-1:0]  data0,
    input  logic [W-1:0]  data1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          so,
    output logic          sv,
    input  logic          det,
    output logic [HW-1:0] hits,
    output logic          done,
    output logic          owner
);

    localparam int CW = cnt_width(W, GAP);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [W-1:0]    sr_q,    sr_d;
    logic [HW-1:0]   hits_q,  hits_d;
    logic            owner_q, owner_d;
    logic            win_q,   win_d;    // SHIFT delayed by one: the det window
    logic            last_q,  last_d;   // marks the window's final sample cycle
    logic            done_q,  done_d;

    logic [1:0]      gnt;
    logic            arb_en;

    // Gating with rst keeps the grants low while reset is held.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arb2 u_arb (
        .c   (c),
        .rst (rst),
        .req ({req1, req0}),
        .en  (arb_en),
        .gnt (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        hits_d  = hits_q;
        owner_d = owner_q;

        // The detector answers one cycle after each serial bit, so the
        // sampling window is the SHIFT phase shifted by one cycle.
        win_d  = (state_q == ST_SHIFT);
        last_d = (state_q == ST_SHIFT) && (cnt_q == SHIFT_LAST);
        done_d = last_q;

        if (win_q && det) begin
            hits_d = hits_q + HW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    sr_d    = gnt[1] ? data1 : data0;
                    owner_d = gnt[1];
                    hits_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d = {1'b0, sr_q[W-1:1]};
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            hits_q  <= '0;
            owner_q <= 1'b0;
            win_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            hits_q  <= hits_d;
            owner_q <= owner_d;
            win_q   <= win_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Serial outputs decode straight from state so reset clears them at once.
    assign sv    = (state_q == ST_SHIFT);
    assign so    = (state_q == ST_SHIFT) && sr_q[0];
    assign gnt0  = gnt[0];
    assign gnt1  = gnt[1];
    assign hits  = hits_q;
    assign done  = done_q;
    assign owner = owner_q;

endmodule
